up_control: RTL and testbench
=============================

# up_control

Control unit for the simple-machine processor datapath with memory-mapped I/O. It is a Moore FSM that decodes the 4-bit opcode from the datapath's instruction register and drives every datapath strobe: mux select, ALU op, RAM write, register write enables and memory/IO source select. It also runs a valid/ack handshake with the external input and output ports, with an optional wait timeout. It sits beside the datapath in the processor top level and is the only agent that sequences it.

## Interface
- IO_TIMEOUT, 0, maximum cycles spent waiting in IN_WAIT/OUT_WAIT; 0 = wait forever
- TW, 8, width of timeout counter; IO_TIMEOUT < 2^TW
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- cop  in  4  opcode, datapath ir[15:12]
- fz  in  1  datapath zero flag
- in_valid  in  1  input port holds valid data on inport
- out_ready  in  1  output port accepts mem_out this cycle
- mx1, mx0  out  1 each  address mux select: 00 pc, 01 zero, 10 src ir[13:7], 11 dst ir[6:0]
- alu_op1, alu_op0  out  1 each  ALU op: 00 ADD, 01 SUB, 10 pass-A
- le  out  1  RAM write enable
- pc_w, ir_w, a_w, b_w, fz_w  out  1 each  datapath register write enables
- mx_memio  out  1  RAM write data: 1 inport, 0 ALU
- in_ack  out  1  input word consumed this cycle
- out_valid  out  1  mem_out/dirport valid for output port
- halted  out  1  in HALT state
- io_err  out  1  sticky; an I/O wait timed out
- state  out  4  current state, debug

## Operation
- Opcode classes: cop[3:2]=00 ADD, 01 MOV, 10 SUB (cop[1:0] are src bits, ignored); 11 extended on cop[1:0]: 00 BEQ, 01 IN, 10 OUT, 11 HALT.
- All outputs are 0 unless listed. Outputs are decoded from state only, except in_ack, le and mx_memio in IN_WAIT.
- BOOT: mx=01, ir_w, pc_w. This loads ir<=mem[0] and pc<=1. Next: DECODE.
- FETCH: mx=00, ir_w, pc_w. Next: DECODE.
- DECODE: no strobes. ADD/SUB/MOV go to RD_A. BEQ goes to JUMP if fz=1, else FETCH. IN goes to IN_WAIT. OUT goes to OUT_WAIT. HALT goes to HALT.
- RD_A: mx=10, a_w. Next: EXEC for MOV, RD_B otherwise.
- RD_B: mx=11, b_w. Next: EXEC.
- EXEC: mx=11, le, mx_memio=0. alu_op is 00 for ADD, 01 for SUB, 10 for MOV. fz_w is set for ADD/SUB only. Next: FETCH.
- JUMP: mx=11, ir_w, pc_w. This fetches ir<=mem[target] and pc<=target+1. Next: DECODE.
- IN_WAIT: mx=11 held. When in_valid=1: le, mx_memio=1, in_ack, then go to FETCH. Otherwise stay.
- OUT_WAIT: mx=11, out_valid held. When out_ready=1, go to FETCH. Otherwise stay.
- HALT: halted=1 and no strobes. Only reset leaves HALT.
- Timeout counter: cleared on entry to a wait state; increments each waiting cycle. If IO_TIMEOUT≠0 and count==IO_TIMEOUT-1 without a handshake:
  - set io_err
  - no RAM write
  - go to FETCH (the instruction is skipped)
- A handshake and a timeout in the same cycle: the handshake wins.
- in_valid and out_ready are ignored outside their wait state.

## Timing
- Reset: during the reset cycle all strobes=0, in_ack=0, out_valid=0, halted=0, io_err cleared. state=BOOT on the following cycle.
- Reset asserted in any state, including mid-wait, forces BOOT. A pending handshake is dropped.
- RAM read is combinational. Datapath registers capture mem_out at the edge ending the strobe cycle.
- Cycles per instruction, fetch included:
  - ADD/SUB: 5
  - MOV: 4
  - BEQ not taken: 2
  - BEQ taken: 3, target already fetched
  - IN/OUT: 3 + wait cycles
  - First instruction after BOOT: 1 fewer, because BOOT performs the fetch.
- fz updates only at the end of ADD/SUB EXEC. BEQ in DECODE sees the value from the last ADD/SUB.
- out_valid asserts from the first OUT_WAIT cycle and stays high until the out_ready cycle inclusive.

## Test plan
- Reset, then program mem[0]=ADD src 5 dst 6 with mem[5]=3, mem[6]=4 -> states BOOT,DECODE,RD_A,RD_B,EXEC; mem[6]=7; fz_w pulses once; fz=0.
- SUB with equal operands, then BEQ to 20 -> JUMP entered; ir=mem[20] and pc=21 after JUMP; BEQ with fz=0 -> FETCH after 2 cycles.
- IN to 9, in_valid held low 4 cycles then high -> le, mx_memio and in_ack high for exactly one cycle; mem[9]=inport; no timeout with IO_TIMEOUT=0.
- OUT from 9, out_ready low 3 cycles -> out_valid high 4 cycles, dirport stable, then FETCH.
- IO_TIMEOUT=5, IN with in_valid never high -> 5 wait cycles, le never asserted, io_err=1 and sticky, next instruction executes; in_valid rising on the 5th cycle -> write happens and io_err stays 0.
- Reset asserted in RD_B and in IN_WAIT -> BOOT next cycle, no le pulse, io_err=0; HALT holds halted=1 indefinitely until reset.

Source files
------------

// File: rtl/up_control.sv
// Moore control unit for the simple-machine datapath: sequences fetch/decode/execute
// and runs the valid/ack handshakes with the external input and output ports.
module up_control #(
    parameter int unsigned IO_TIMEOUT = 0,
    parameter int unsigned TW         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cop,
    input  logic       fz,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       mx1,
    output logic       mx0,
    output logic       alu_op1,
    output logic       alu_op0,
    output logic       le,
    output logic       pc_w,
    output logic       ir_w,
    output logic       a_w,
    output logic       b_w,
    output logic       fz_w,
    output logic       mx_memio,
    output logic       in_ack,
    output logic       out_valid,
    output logic       halted,
    output logic       io_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_BOOT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_RD_A     = 4'd3,
        S_RD_B     = 4'd4,
        S_EXEC     = 4'd5,
        S_JUMP     = 4'd6,
        S_IN_WAIT  = 4'd7,
        S_OUT_WAIT = 4'd8,
        S_HALT     = 4'd9
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    state_t        st;
    logic [1:0]    op_q;
    logic [TW-1:0] wait_cnt;
    logic          err_q;
    logic          to_hit;
    logic [1:0]    mx;
    logic [1:0]    alu_op;

    // The timeout fires on the last permitted wait cycle; a handshake that cycle wins.
    always_comb begin
        to_hit = (IO_TIMEOUT != 0) && (wait_cnt == TW'(IO_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= S_BOOT;
            op_q     <= OP_ADD;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (st)
                S_BOOT:   st <= S_DECODE;
                S_FETCH:  st <= S_DECODE;
                S_JUMP:   st <= S_DECODE;
                S_DECODE: begin
                    op_q     <= cop[3:2];
                    wait_cnt <= '0;
                    if (cop[3:2] == 2'b11) begin
                        case (cop[1:0])
                            2'b00:   st <= fz ? S_JUMP : S_FETCH;
                            2'b01:   st <= S_IN_WAIT;
                            2'b10:   st <= S_OUT_WAIT;
                            default: st <= S_HALT;
                        endcase
                    end else begin
                        st <= S_RD_A;
                    end
                end
                S_RD_A:   st <= (op_q == OP_MOV) ? S_EXEC : S_RD_B;
                S_RD_B:   st <= S_EXEC;
                S_EXEC:   st <= S_FETCH;
                // Handshake: the peer's valid/ready is sampled only in its own wait
                // state; the transfer completes in the cycle it is seen high.
                S_IN_WAIT: begin
                    if (in_valid) begin
                        st <= S_FETCH;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        st    <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready) begin
                        st <= S_FETCH;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        st    <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_HALT:   st <= S_HALT;
                default:  st <= S_BOOT;
            endcase
        end
    end

    // Strobes come from the registered state; only the IN_WAIT write path looks at
    // in_valid. Everything is held low while reset is asserted.
    always_comb begin
        mx        = 2'b00;
        alu_op    = 2'b00;
        le        = 1'b0;
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        a_w       = 1'b0;
        b_w       = 1'b0;
        fz_w      = 1'b0;
        mx_memio  = 1'b0;
        in_ack    = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;
        if (!reset) begin
            case (st)
                S_BOOT: begin
                    mx   = 2'b01;
                    ir_w = 1'b1;
                    pc_w = 1'b1;
                end
                S_FETCH: begin
                    ir_w = 1'b1;
                    pc_w = 1'b1;
                end
                S_RD_A: begin
                    mx  = 2'b10;
                    a_w = 1'b1;
                end
                S_RD_B: begin
                    mx  = 2'b11;
                    b_w = 1'b1;
                end
                S_EXEC: begin
                    mx     = 2'b11;
                    le     = 1'b1;
                    alu_op = (op_q == OP_SUB) ? 2'b01 : (op_q == OP_MOV) ? 2'b10 : 2'b00;
                    fz_w   = (op_q != OP_MOV);
                end
                S_JUMP: begin
                    mx   = 2'b11;
                    ir_w = 1'b1;
                    pc_w = 1'b1;
                end
                S_IN_WAIT: begin
                    mx       = 2'b11;
                    le       = in_valid;
                    mx_memio = in_valid;
                    in_ack   = in_valid;
                end
                S_OUT_WAIT: begin
                    mx        = 2'b11;
                    out_valid = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: mx = 2'b00;
            endcase
        end
    end

    assign mx1     = mx[1];
    assign mx0     = mx[0];
    assign alu_op1 = alu_op[1];
    assign alu_op0 = alu_op[0];
    assign io_err  = err_q & ~reset;
    assign state   = st;

endmodule

// File: tb/tb_up_control.sv
// Directed bench for up_control: a behavioural datapath runs small programs on one
// instance, a second instance with IO_TIMEOUT=5 is driven directly for the timeout cases.
module tb_up_control;

    localparam int S_BOOT = 0, S_FETCH = 1, S_DECODE = 2, S_RD_A = 3, S_RD_B = 4;
    localparam int S_EXEC = 5, S_JUMP = 6, S_IN_WAIT = 7, S_OUT_WAIT = 8, S_HALT = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- main DUT + datapath model ----------------
    logic        fz_q;
    logic        in_valid, out_ready;
    logic        mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w;
    logic        mx_memio, in_ack, out_valid, halted, io_err;
    logic [3:0]  dut_state;

    logic [15:0] mem [0:127];
    logic [15:0] ir, a_r, b_r, inport, mem_out, alu;
    logic [6:0]  pc, addr;
    logic        ld_en;
    logic [6:0]  ld_addr;
    logic [15:0] ld_data;
    int          fzw_cnt, ack_cnt, ov_cnt, le_cnt;

    up_control #(.IO_TIMEOUT(0), .TW(8)) dut (
        .clk(clk), .reset(reset), .cop(ir[15:12]), .fz(fz_q),
        .in_valid(in_valid), .out_ready(out_ready),
        .mx1(mx1), .mx0(mx0), .alu_op1(alu_op1), .alu_op0(alu_op0),
        .le(le), .pc_w(pc_w), .ir_w(ir_w), .a_w(a_w), .b_w(b_w), .fz_w(fz_w),
        .mx_memio(mx_memio), .in_ack(in_ack), .out_valid(out_valid),
        .halted(halted), .io_err(io_err), .state(dut_state)
    );

    always_comb begin
        case ({mx1, mx0})
            2'b00:   addr = pc;
            2'b01:   addr = 7'd0;
            2'b10:   addr = ir[13:7];
            default: addr = ir[6:0];
        endcase
        mem_out = mem[addr];
        case ({alu_op1, alu_op0})
            2'b00:   alu = a_r + b_r;
            2'b01:   alu = a_r - b_r;
            default: alu = a_r;
        endcase
    end

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (le) mem[addr] <= mx_memio ? inport : alu;
        if (ir_w) ir <= mem_out;
        if (pc_w) pc <= addr + 7'd1;
        if (a_w) a_r <= mem_out;
        if (b_w) b_r <= mem_out;
        if (fz_w) fz_q <= (alu == 16'd0);
        if (fz_w) fzw_cnt <= fzw_cnt + 1;
        if (in_ack) ack_cnt <= ack_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
        if (le) le_cnt <= le_cnt + 1;
    end

    // ---------------- timeout DUT, driven directly ----------------
    logic       t_reset, t_in_valid, t_out_ready;
    logic [3:0] t_cop;
    logic       t_mx1, t_mx0, t_alu_op1, t_alu_op0, t_le, t_pc_w, t_ir_w, t_a_w, t_b_w, t_fz_w;
    logic       t_mx_memio, t_in_ack, t_out_valid, t_halted, t_io_err;
    logic [3:0] t_state;

    up_control #(.IO_TIMEOUT(5), .TW(8)) dut_to (
        .clk(clk), .reset(t_reset), .cop(t_cop), .fz(1'b0),
        .in_valid(t_in_valid), .out_ready(t_out_ready),
        .mx1(t_mx1), .mx0(t_mx0), .alu_op1(t_alu_op1), .alu_op0(t_alu_op0),
        .le(t_le), .pc_w(t_pc_w), .ir_w(t_ir_w), .a_w(t_a_w), .b_w(t_b_w), .fz_w(t_fz_w),
        .mx_memio(t_mx_memio), .in_ack(t_in_ack), .out_valid(t_out_valid),
        .halted(t_halted), .io_err(t_io_err), .state(t_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [6:0] ad, input logic [15:0] d);
        ld_addr = ad;
        ld_data = d;
        ld_en   = 1'b1;
        step();
        ld_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inport = 16'h0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; fz_q = 1'b0;
        fzw_cnt = 0; ack_cnt = 0; ov_cnt = 0; le_cnt = 0;
        t_reset = 1'b1; t_cop = 4'h0; t_in_valid = 1'b0; t_out_ready = 1'b0;

        load(7'd0,  16'h0286);  // ADD src 5 dst 6
        load(7'd1,  16'h850B);  // SUB src 10 dst 11
        load(7'd2,  16'hC014);  // BEQ 20
        load(7'd5,  16'd3);
        load(7'd6,  16'd4);
        load(7'd10, 16'd2);
        load(7'd11, 16'd2);
        load(7'd20, 16'h0286);  // ADD src 5 dst 6
        load(7'd21, 16'hC028);  // BEQ 40
        load(7'd22, 16'hD009);  // IN dst 9
        load(7'd23, 16'hE009);  // OUT from 9
        load(7'd24, 16'h448C);  // MOV src 9 dst 12
        load(7'd25, 16'hF000);  // HALT

        check("rst_state", dut_state, S_BOOT);
        check("rst_outputs", {le, ir_w, pc_w, a_w, b_w, fz_w, in_ack, out_valid, halted, io_err}, 0);
        reset = 1'b0;
        #1;
        check("boot_strobes", {mx1, mx0, ir_w, pc_w}, 4'b0111);

        // ADD: 3 + 4 -> mem[6]
        c0 = fzw_cnt;
        step(); check("add_decode", dut_state, S_DECODE);
        step(); check("add_rd_a", {dut_state, mx1, mx0, a_w}, {4'(S_RD_A), 3'b101});
        step(); check("add_rd_b", {dut_state, mx1, mx0, b_w}, {4'(S_RD_B), 3'b111});
        step(); check("add_exec", {dut_state, le, mx_memio, alu_op1, alu_op0, fz_w}, {4'(S_EXEC), 5'b10001});
        step(); check("add_fetch", dut_state, S_FETCH);
        check("add_result", mem[6], 16'd7);
        check("add_fz", fz_q, 1'b0);
        check("add_fzw_pulses", fzw_cnt - c0, 1);

        // SUB equal operands -> fz=1, then BEQ taken to 20
        step(); step(); step();
        step(); check("sub_exec", {dut_state, le, alu_op1, alu_op0, fz_w}, {4'(S_EXEC), 4'b1011});
        step(); check("sub_fz", fz_q, 1'b1);
        check("sub_result", mem[11], 16'd0);
        step(); check("beq_decode", dut_state, S_DECODE);
        step(); check("beq_taken", dut_state, S_JUMP);
        step(); check("jump_decode", dut_state, S_DECODE);
        check("jump_ir", ir, 16'h0286);
        check("jump_pc", pc, 7'd21);

        // ADD 3 + 7 -> mem[6]=10, fz=0; BEQ not taken
        step(); step(); step(); step();
        check("add2_result", mem[6], 16'd10);
        check("add2_fz", fz_q, 1'b0);
        step(); step(); check("beq_not_taken", dut_state, S_FETCH);

        // IN with 4 idle cycles
        step(); step(); check("in_wait", dut_state, S_IN_WAIT);
        c0 = ack_cnt;
        for (int i = 0; i < 4; i++) begin
            check("in_idle", {le, mx_memio, in_ack}, 3'b000);
            step();
        end
        in_valid = 1'b1; inport = 16'h1234;
        #1;
        check("in_handshake", {le, mx_memio, in_ack}, 3'b111);
        step();
        in_valid = 1'b0;
        check("in_done", {dut_state, io_err}, {4'(S_FETCH), 1'b0});
        check("in_mem", mem[9], 16'h1234);
        check("in_ack_pulses", ack_cnt - c0, 1);

        // OUT with 3 stalled cycles
        step(); step(); check("out_wait", dut_state, S_OUT_WAIT);
        c0 = ov_cnt;
        for (int i = 0; i < 3; i++) begin
            check("out_hold", {out_valid, mem_out}, {1'b1, 16'h1234});
            step();
        end
        out_ready = 1'b1;
        #1;
        check("out_accept", {out_valid, mem_out}, {1'b1, 16'h1234});
        step();
        out_ready = 1'b0;
        check("out_done", {dut_state, out_valid}, {4'(S_FETCH), 1'b0});
        check("out_valid_cycles", ov_cnt - c0, 4);

        // MOV 9 -> 12
        step(); step(); check("mov_rd_a", dut_state, S_RD_A);
        step(); check("mov_exec", {dut_state, le, alu_op1, alu_op0, fz_w}, {4'(S_EXEC), 4'b1100});
        step(); check("mov_result", mem[12], 16'h1234);

        // HALT holds
        step(); step();
        for (int i = 0; i < 8; i++) begin
            check("halt_hold", {dut_state, halted, ir_w}, {4'(S_HALT), 2'b10});
            step();
        end

        // Reset during RD_B
        reset = 1'b1;
        load(7'd0, 16'h0286);
        reset = 1'b0;
        #1;
        step(); step(); step();
        check("rdb_reached", dut_state, S_RD_B);
        c0 = le_cnt;
        reset = 1'b1;
        #1;
        check("rdb_reset_outputs", {le, b_w, halted, io_err}, 4'b0000);
        step();
        check("rdb_reset_boot", dut_state, S_BOOT);
        check("rdb_no_le", le_cnt - c0, 0);

        // Reset during IN_WAIT with in_valid pending
        load(7'd0, 16'hD009);
        reset = 1'b0;
        #1;
        step(); step();
        check("inw_reached", dut_state, S_IN_WAIT);
        c0 = le_cnt;
        in_valid = 1'b1; inport = 16'hBEEF; reset = 1'b1;
        #1;
        check("inw_reset_outputs", {le, in_ack, io_err}, 3'b000);
        step();
        in_valid = 1'b0;
        check("inw_reset_boot", dut_state, S_BOOT);
        check("inw_no_write", mem[9], 16'h1234);
        check("inw_no_le", le_cnt - c0, 0);
        reset = 1'b0;

        // Timeout: IN never answered
        t_cop = 4'hD;
        step();
        t_reset = 1'b0;
        #1;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            check("to_wait", {t_state, t_le, t_io_err}, {4'(S_IN_WAIT), 2'b00});
            step();
        end
        check("to_skip", {t_state, t_io_err}, {4'(S_FETCH), 1'b1});
        t_cop = 4'h4;
        step(); step();
        check("to_next_instr", t_state, S_RD_A);
        step(); check("to_next_exec", {t_state, t_le, t_io_err}, {4'(S_EXEC), 2'b11});
        step(); check("to_sticky", t_io_err, 1'b1);

        // Handshake on the last permitted cycle beats the timeout
        t_reset = 1'b1;
        step();
        t_reset = 1'b0;
        t_cop = 4'hD;
        #1;
        check("to_err_cleared", t_io_err, 1'b0);
        step(); step();
        for (int i = 0; i < 4; i++) step();
        check("to_last_cycle", t_state, S_IN_WAIT);
        t_in_valid = 1'b1;
        #1;
        check("to_late_handshake", {t_le, t_mx_memio, t_in_ack}, 3'b111);
        step();
        t_in_valid = 1'b0;
        check("to_late_done", {t_state, t_io_err}, {4'(S_FETCH), 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
